// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: the E-stage control bundle, its bubble value and
// the data bundle carried alongside it.
package rv32i_pkg;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       jump;
    logic       branch;
    logic       alubsrc;
    logic       pctargetalusrc;
    logic [1:0] resultsrc;
    logic [1:0] aluasrc;
    logic [1:0] memwrite;
    logic [3:0] alucontrol;
    logic [2:0] loadsize;
    logic [2:0] funct3;
  } ctrl_e_t;

  localparam ctrl_e_t CTRL_NOP = '0;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] immext;
    logic [31:0] pcplus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } data_e_t;

  // Invalid slots become bubbles; a write to x0 is never exposed downstream.
  function automatic ctrl_e_t ctrl_gate(input ctrl_e_t c, input logic [4:0] rd);
    ctrl_e_t g;
    g = c;
    if (rd == 5'd0) g.regwrite = 1'b0;
    if (!c.valid)   g = CTRL_NOP;
    return g;
  endfunction

endpackage

// File: rtl/idex_reg_if.sv
// Decode-to-execute pipeline bundle: D-side inputs, flush/stall, E-side outputs.
interface idex_reg_if;
  logic        FlushE, StallE;
  logic        ValidD, ValidE;
  logic        RegWriteD, JumpD, BranchD, ALUBSrcD, PCTargetALUSrcD;
  logic        RegWriteE, JumpE, BranchE, ALUBSrcE, PCTargetALUSrcE;
  logic [1:0]  ResultSrcD, ALUASrcD, MemWriteD;
  logic [1:0]  ResultSrcE, ALUASrcE, MemWriteE;
  logic [3:0]  ALUControlD, ALUControlE;
  logic [2:0]  LoadSizeD, LoadSizeE;
  logic [2:0]  funct3D, funct3E;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [4:0]  Rs1E, Rs2E, RdE;

  modport master (
    output FlushE, StallE, ValidD,
    output RegWriteD, JumpD, BranchD, ALUBSrcD, PCTargetALUSrcD,
    output ResultSrcD, ALUASrcD, MemWriteD, ALUControlD, LoadSizeD, funct3D,
    output RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD,
    input  ValidE, RegWriteE, JumpE, BranchE, ALUBSrcE, PCTargetALUSrcE,
    input  ResultSrcE, ALUASrcE, MemWriteE, ALUControlE, LoadSizeE, funct3E,
    input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE
  );

  modport slave (
    input  FlushE, StallE, ValidD,
    input  RegWriteD, JumpD, BranchD, ALUBSrcD, PCTargetALUSrcD,
    input  ResultSrcD, ALUASrcD, MemWriteD, ALUControlD, LoadSizeD, funct3D,
    input  RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD,
    output ValidE, RegWriteE, JumpE, BranchE, ALUBSrcE, PCTargetALUSrcE,
    output ResultSrcE, ALUASrcE, MemWriteE, ALUControlE, LoadSizeE, funct3E,
    output RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/idex_reg_flopenrc.sv
// Generic register: async reset, synchronous clear, enable (reset > clr > en).
module flopenrc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/idex_reg.sv
// ID/EX pipeline register: control and data bundles held in two flopenrc
// instances; flush beats stall, and stall holds every field.
module idex_reg
  import rv32i_pkg::*;
#(
  parameter bit NOP_ON_FLUSH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  idex_reg_if.slave   bus
);

  ctrl_e_t ctrl_d, ctrl_q;
  data_e_t data_d, data_q;

  always_comb begin
    ctrl_d                = CTRL_NOP;
    ctrl_d.valid          = bus.ValidD;
    ctrl_d.regwrite       = bus.RegWriteD;
    ctrl_d.jump           = bus.JumpD;
    ctrl_d.branch         = bus.BranchD;
    ctrl_d.alubsrc        = bus.ALUBSrcD;
    ctrl_d.pctargetalusrc = bus.PCTargetALUSrcD;
    ctrl_d.resultsrc      = bus.ResultSrcD;
    ctrl_d.aluasrc        = bus.ALUASrcD;
    ctrl_d.memwrite       = bus.MemWriteD;
    ctrl_d.alucontrol     = bus.ALUControlD;
    ctrl_d.loadsize       = bus.LoadSizeD;
    ctrl_d.funct3         = bus.funct3D;
    ctrl_d                = ctrl_gate(ctrl_d, bus.RdD);
  end

  assign data_d = '{rd1: bus.RD1D, rd2: bus.RD2D, pc: bus.PCD,
                    immext: bus.ImmExtD, pcplus4: bus.PCPlus4D,
                    rs1: bus.Rs1D, rs2: bus.Rs2D, rd: bus.RdD};

  flopenrc #(.WIDTH($bits(ctrl_e_t))) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .en    (~bus.StallE),
    .clr   (bus.FlushE),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  // Without NOP_ON_FLUSH the data bundle ignores flush and just follows stall.
  flopenrc #(.WIDTH($bits(data_e_t))) u_data (
    .clk   (clk),
    .reset (reset),
    .en    (~bus.StallE),
    .clr   (bus.FlushE & NOP_ON_FLUSH),
    .d     (data_d),
    .q     (data_q)
  );

  assign bus.ValidE          = ctrl_q.valid;
  assign bus.RegWriteE       = ctrl_q.regwrite;
  assign bus.JumpE           = ctrl_q.jump;
  assign bus.BranchE         = ctrl_q.branch;
  assign bus.ALUBSrcE        = ctrl_q.alubsrc;
  assign bus.PCTargetALUSrcE = ctrl_q.pctargetalusrc;
  assign bus.ResultSrcE      = ctrl_q.resultsrc;
  assign bus.ALUASrcE        = ctrl_q.aluasrc;
  assign bus.MemWriteE       = ctrl_q.memwrite;
  assign bus.ALUControlE     = ctrl_q.alucontrol;
  assign bus.LoadSizeE       = ctrl_q.loadsize;
  assign bus.funct3E         = ctrl_q.funct3;

  assign bus.RD1E            = data_q.rd1;
  assign bus.RD2E            = data_q.rd2;
  assign bus.PCE             = data_q.pc;
  assign bus.ImmExtE         = data_q.immext;
  assign bus.PCPlus4E        = data_q.pcplus4;
  assign bus.Rs1E            = data_q.rs1;
  assign bus.Rs2E            = data_q.rs2;
  assign bus.RdE             = data_q.rd;

endmodule

// File: tb/tb_idex_reg.sv
// Directed self-checking bench for idex_reg (NOP_ON_FLUSH=1).
module tb_idex_reg;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  idex_reg_if bus ();

  idex_reg #(.NOP_ON_FLUSH(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] all_out();
    return {bus.ValidE, bus.RegWriteE, bus.JumpE, bus.BranchE, bus.ALUBSrcE,
            bus.PCTargetALUSrcE, bus.ResultSrcE, bus.ALUASrcE, bus.MemWriteE,
            bus.ALUControlE, bus.LoadSizeE, bus.funct3E, bus.RD1E, bus.RD2E,
            bus.PCE, bus.ImmExtE, bus.PCPlus4E, bus.Rs1E, bus.Rs2E, bus.RdE};
  endfunction

  task automatic clear_inputs();
    bus.FlushE = 1'b0;  bus.StallE = 1'b0;  bus.ValidD = 1'b0;
    bus.RegWriteD = 1'b0; bus.JumpD = 1'b0; bus.BranchD = 1'b0;
    bus.ALUBSrcD = 1'b0;  bus.PCTargetALUSrcD = 1'b0;
    bus.ResultSrcD = '0;  bus.ALUASrcD = '0; bus.MemWriteD = '0;
    bus.ALUControlD = '0; bus.LoadSizeD = '0; bus.funct3D = '0;
    bus.RD1D = '0; bus.RD2D = '0; bus.PCD = '0; bus.ImmExtD = '0; bus.PCPlus4D = '0;
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    reset = 1'b1;

    // reset wins over live inputs
    bus.ValidD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = 5'd7; bus.RD1D = 32'hFFFF_FFFF;
    tick(); tick();
    chk("reset_all_zero", all_out(), '0);

    #3 reset = 1'b0;
    clear_inputs();

    // load
    bus.ValidD = 1'b1; bus.RegWriteD = 1'b1; bus.RdD = 5'd5; bus.RD1D = 32'h0000_1234;
    bus.RD2D = 32'hAAAA_5555; bus.PCD = 32'h0000_0100; bus.ImmExtD = 32'hFFFF_FFF0;
    bus.PCPlus4D = 32'h0000_0104; bus.Rs1D = 5'd3; bus.Rs2D = 5'd7;
    bus.ResultSrcD = 2'd2; bus.ALUASrcD = 2'd1; bus.MemWriteD = 2'b01;
    bus.ALUControlD = 4'hA; bus.LoadSizeD = 3'b101; bus.funct3D = 3'b110;
    bus.BranchD = 1'b1; bus.ALUBSrcD = 1'b1; bus.PCTargetALUSrcD = 1'b1;
    #1;
    chk("no_comb_path", all_out(), '0);
    tick();
    chk("load_rd1", bus.RD1E, 32'h0000_1234);
    chk("load_rd", bus.RdE, 5'd5);
    chk("load_regwrite", bus.RegWriteE, 1'b1);
    chk("load_valid", bus.ValidE, 1'b1);
    chk("load_data", {bus.RD2E, bus.PCE, bus.ImmExtE, bus.PCPlus4E, bus.Rs1E, bus.Rs2E},
        {32'hAAAA_5555, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0000_0104, 5'd3, 5'd7});
    chk("load_ctrl", {bus.JumpE, bus.BranchE, bus.ALUBSrcE, bus.PCTargetALUSrcE,
                      bus.ResultSrcE, bus.ALUASrcE, bus.MemWriteE, bus.ALUControlE,
                      bus.LoadSizeE, bus.funct3E},
        {1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1, 2'b01, 4'hA, 3'b101, 3'b110});

    // stall for three cycles while inputs change
    bus.StallE = 1'b1;
    bus.RD1D = 32'hDEAD_BEEF; bus.RdD = 5'd9; bus.PCD = 32'h0000_0200; bus.MemWriteD = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", {bus.RD1E, bus.RdE, bus.PCE, bus.MemWriteE, bus.ValidE},
          {32'h0000_1234, 5'd5, 32'h0000_0100, 2'b01, 1'b1});
      bus.RD1D = bus.RD1D + 32'd1;
    end
    bus.RD1D = 32'hDEAD_BEEF;
    bus.StallE = 1'b0;
    tick();
    chk("stall_release", {bus.RD1E, bus.RdE, bus.PCE, bus.MemWriteE},
        {32'hDEAD_BEEF, 5'd9, 32'h0000_0200, 2'b10});

    // flush together with stall gives a bubble
    bus.FlushE = 1'b1; bus.StallE = 1'b1; bus.MemWriteD = 2'b10; bus.RD2D = 32'h1111_2222;
    tick();
    chk("flush_memwrite", bus.MemWriteE, 2'b00);
    chk("flush_regwrite", bus.RegWriteE, 1'b0);
    chk("flush_valid", bus.ValidE, 1'b0);
    chk("flush_rd2", bus.RD2E, 32'h0);
    chk("flush_all_zero", all_out(), '0);

    // x0 destination, memwrite/loadsize pass-through
    bus.FlushE = 1'b0; bus.StallE = 1'b0;
    bus.RdD = 5'd0; bus.RegWriteD = 1'b1; bus.ValidD = 1'b1;
    bus.MemWriteD = 2'b10; bus.LoadSizeD = 3'b010;
    tick();
    chk("x0_regwrite", bus.RegWriteE, 1'b0);
    chk("x0_rd", bus.RdE, 5'd0);
    chk("x0_passthru", {bus.ValidE, bus.MemWriteE, bus.LoadSizeE}, {1'b1, 2'b10, 3'b010});

    // invalid fetch becomes a control bubble, data still loads
    bus.ValidD = 1'b0; bus.JumpD = 1'b1; bus.BranchD = 1'b1; bus.RegWriteD = 1'b1;
    bus.RdD = 5'd4; bus.RD1D = 32'h0000_5555;
    tick();
    chk("inv_jump_branch_valid", {bus.JumpE, bus.BranchE, bus.ValidE}, 3'b000);
    chk("inv_ctrl_zero", {bus.RegWriteE, bus.MemWriteE, bus.LoadSizeE, bus.ALUControlE,
                          bus.funct3E, bus.ALUBSrcE, bus.PCTargetALUSrcE}, '0);
    chk("inv_data", {bus.RdE, bus.RD1E}, {5'd4, 32'h0000_5555});

    // async reset mid-stall
    bus.ValidD = 1'b1; bus.JumpD = 1'b0; bus.BranchD = 1'b0; bus.RdD = 5'd3;
    bus.RD1D = 32'h0000_0077; bus.PCD = 32'h0000_0300;
    tick();
    chk("pre_reset_load", {bus.RD1E, bus.RegWriteE, bus.RdE}, {32'h0000_0077, 1'b1, 5'd3});
    bus.StallE = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_reset_zero", all_out(), '0);
    #2 reset = 1'b0;
    bus.StallE = 1'b0; bus.PCD = 32'h0000_0040;
    #1;
    chk("post_reset_pre_edge", bus.PCE, 32'h0);
    tick();
    chk("post_reset_load_pc", bus.PCE, 32'h0000_0040);
    chk("post_reset_valid", bus.ValidE, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idex_reg.md
IDEX_REG -- requirements
Module: idex_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports FlushE, input, 1 bit: clear the stage to a bubble on the next edge.
REQ-004 SHALL have ports StallE, input, 1 bit: hold the current E contents.
REQ-005 SHALL have ports ValidD (input, 1 bit) and ValidE (output, 1 bit): instruction-valid flag.
REQ-006 SHALL have ports RegWriteD, JumpD, BranchD, ALUBSrcD and PCTargetALUSrcD (inputs, 1 bit each), registered to *E outputs of 1 bit each.
REQ-007 SHALL have ports ResultSrcD, ALUASrcD and MemWriteD (inputs, 2 bits each), registered to *E outputs of 2 bits each.
REQ-008 SHALL have ports ALUControlD (input, 4 bits) and LoadSizeD (input, 3 bits), registered to *E outputs of the same widths.
REQ-009 SHALL have ports funct3D (input, 3 bits) registered to funct3E (output, 3 bits): branch-condition select.
REQ-010 SHALL have ports RD1D, RD2D, PCD, ImmExtD and PCPlus4D (inputs, 32 bits each), registered to *E outputs of 32 bits each.
REQ-011 SHALL have ports Rs1D, Rs2D and RdD (inputs, 5 bits each), registered to *E outputs of 5 bits each, for the hazard unit.
REQ-012 SHALL provide a parameter NOP_ON_FLUSH, default 1: 1 clears all fields on flush; 0 clears only control fields and ValidE.

Function
REQ-013 SHALL resolve per-edge priority as reset > FlushE > StallE > load.
REQ-014 SHALL, on load (FlushE=0, StallE=0), copy every D input to its E output with a latency of exactly 1 cycle.
REQ-015 SHALL, while StallE=1 and FlushE=0, hold every E output unchanged, for any number of cycles.
REQ-016 SHALL, on FlushE=1, force RegWriteE, MemWriteE, JumpE, BranchE and ValidE to 0 and every other control field to 0.
REQ-017 SHALL, on FlushE=1 with NOP_ON_FLUSH=1, also force all data and register-index fields to 0.
REQ-018 SHALL treat FlushE=1 with StallE=1 as a flush, and produce a bubble.
REQ-019 SHALL force RegWriteE to 0 whenever RdD=0 is loaded, so that an x0 destination never appears writable downstream.
REQ-020 SHALL force all control outputs to 0 when ValidD=0 is loaded, so that invalid fetches become bubbles.
REQ-021 SHALL not combinationally pass any input to any output; all outputs come directly from flops.
REQ-022 SHALL pass MemWriteE (2-bit encoding) and LoadSizeE through unmodified; this block performs no decoding.

Reset
REQ-023 SHALL, while reset=1, asynchronously drive every output, including ValidE and all data fields, to 0, regardless of clk.
REQ-024 SHALL, when reset is asserted mid-stall or mid-flush, go immediately to all-zero and resume normal loading on the first edge after deassertion.

Structure
REQ-025 SHALL place the control-bundle struct type (ctrl_e_t) and its all-zero constant CTRL_NOP in the shared package rv32i_pkg, so that the EX/MEM stage can reuse them.
REQ-026 SHALL be built from instances of one generic sub-module, flopenrc (parameterised WIDTH, async reset, enable, synchronous clear), one instance each for the control bundle and the data bundle.

Verification
REQ-027 Load test: RD1D=32'h0000_1234, RdD=5, RegWriteD=1, ValidD=1, no stall or flush -> one edge later RD1E=32'h0000_1234, RdE=5, RegWriteE=1, ValidE=1.
REQ-028 Stall test: StallE=1 for 3 cycles while inputs change -> E outputs equal their pre-stall values for all 3 cycles, then update on the first edge after StallE=0.
REQ-029 Flush test: FlushE=1 and StallE=1 with MemWriteD=2'b10 -> next edge MemWriteE=0, RegWriteE=0, ValidE=0; with NOP_ON_FLUSH=1, RD2E=0.
REQ-030 x0 test: RdD=0, RegWriteD=1 -> RegWriteE=0, RdE=0.
REQ-031 Reset test: assert reset between clock edges with non-zero outputs -> all outputs 0 before the next edge; after deassertion, a load of PCD=32'h0000_0040 gives PCE=32'h0000_0040 one cycle later.
REQ-032 Invalid test: ValidD=0, JumpD=1, BranchD=1 -> JumpE=0, BranchE=0, ValidE=0.
